fifo_word_unpacker: RTL and testbench
=====================================

// Module: fifo_word_unpacker
// PURPOSE
//   Splits a word stream (with per-word byte count and packet-end flag) into a byte
//   stream, MSB first, matching fifo_byte_adapter byte order. Sits between a word FIFO
//   and a byte-wide consumer (e.g. serial TX) where packets end on non-word boundaries.
//   Full ready/valid backpressure on both sides; sustains 1 byte/cycle across words.
// PARAMETERS
//   bytes_per_word  2   bytes per input word (2..8)
//   count_width     4   width of word_in_nbytes and byte output counter index
// PORTS
//   clk_core        in   1                  core clock
//   reset           in   1                  synchronous, active-high reset
//   word_in_ready   out  1                  unpacker can accept a word this cycle
//   word_in_valid   in   1                  word_in_* valid
//   word_in_data    in   bytes_per_word*8   word; byte 0 = bits [bpw*8-1:(bpw-1)*8]
//   word_in_nbytes  in   count_width        valid bytes in word, MSB-aligned (1..bpw)
//   word_in_last    in   1                  word ends a packet
//   byte_out_ready  in   1                  consumer accepts byte this cycle
//   byte_out_valid  out  1                  byte_out_* valid
//   byte_out_data   out  8                  output byte
//   byte_out_last   out  1                  final byte of packet
//   bytes_sent      out  16                 count of bytes transferred out, wraps
// BEHAVIOUR
//   Handshake: transfer when ready && valid, same edge. Once byte_out_valid is high,
//     byte_out_data/last are held stable until transfer. word_in_ready does not depend
//     combinationally on word_in_valid.
//   Reset: word_in_ready=0 during reset, 1 the first cycle after; byte_out_valid=0,
//     byte_out_data=0, byte_out_last=0, bytes_sent=0, state=EMPTY, remaining=0.
//     Reset mid-word discards all held bytes; nothing resumes after reset.
//   State: shift reg sreg[bpw*8-1:0], remaining count rem, flag pkt_last.
//     EMPTY: byte_out_valid=0, word_in_ready=1. On word accept: load sreg, rem=nbytes,
//       pkt_last=last; next cycle byte_out_valid=1 with byte 0 -> state ACTIVE.
//       Latency word accept -> first byte valid: 1 cycle.
//     ACTIVE: on byte transfer, shift sreg left 8, rem-=1, bytes_sent+=1.
//       word_in_ready=1 only when (rem==1 && byte_out_ready) or !byte_out_valid, so a
//       new word loads on the same edge the last byte of the current word leaves
//       (no bubble). If rem reaches 0 with no new word -> EMPTY.
//   byte_out_last = pkt_last && (rem==1); asserted only on the final valid byte.
//   nbytes: 0 or >bpw treated as bpw. Bytes beyond nbytes are dropped, never output.
//   Simultaneous last-byte transfer and word accept: new word's byte 0 valid next cycle.
//   byte_out_ready low indefinitely: state and outputs frozen, word_in_ready=0 unless EMPTY.
//   bytes_sent wraps 16'hFFFF -> 0.
//   Widths: rem is count_width bits; count_width must hold bpw.
// TESTING
//   bpw=2, word 16'hA1B2 nbytes=2 last=1, ready=1 -> bytes A1, B2 on consecutive
//     cycles, last=1 only on B2, bytes_sent=2.
//   Back-to-back words 16'h0102,16'h0304 (nbytes=2), ready=1 -> 01,02,03,04 on 4
//     consecutive cycles, no bubble, word_in_ready high on the cycle 02 transfers.
//   Word 16'hC3D4 nbytes=1 last=1 -> single byte C3 with last=1; D4 never appears.
//   ready toggled 1,0,0,1 during word 16'h5566 -> 55 transfers, 66 held stable 2
//     cycles then transfers; no duplicate or lost byte.
//   Reset asserted after first byte of 16'h7788 -> byte_out_valid=0, bytes_sent=0
//     next cycle; 88 never emitted; next word 16'h99AA outputs 99,AA normally.
//   bpw=4, nbytes=0 word 32'h11223344 -> 11,22,33,44 (treated as full word).

Source files
------------

// File: rtl/fifo_word_unpacker.sv
// Word-to-byte unpacker: emits the valid bytes of each input word MSB first,
// with ready/valid on both sides and no bubble between consecutive words.
module fifo_word_unpacker #(
    parameter int bytes_per_word = 2,
    parameter int count_width    = 4
) (
    input  logic                          clk_core,
    input  logic                          reset,
    output logic                          word_in_ready,
    input  logic                          word_in_valid,
    input  logic [bytes_per_word*8-1:0]   word_in_data,
    input  logic [count_width-1:0]        word_in_nbytes,
    input  logic                          word_in_last,
    input  logic                          byte_out_ready,
    output logic                          byte_out_valid,
    output logic [7:0]                    byte_out_data,
    output logic                          byte_out_last,
    output logic [15:0]                   bytes_sent
);

    localparam int                     W     = bytes_per_word * 8;
    localparam logic [count_width-1:0] BPW_C = count_width'(bytes_per_word);
    localparam logic [count_width-1:0] ONE_C = count_width'(1);

    typedef enum logic [0:0] {
        ST_EMPTY  = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [W-1:0]           r_sreg;
    logic [W-1:0]           w_sreg_nxt;
    logic [count_width-1:0] r_rem;
    logic [count_width-1:0] w_rem_nxt;
    logic                   r_pkt_last;
    logic                   w_pkt_last_nxt;
    logic [15:0]            r_bytes_sent;
    logic [15:0]            w_bytes_sent_nxt;
    logic                   w_accept;
    logic                   w_xfer;
    logic                   w_ready;

    // Zero or oversized byte counts mean "whole word".
    function automatic logic [count_width-1:0] clamp_nbytes(input logic [count_width-1:0] n);
        if ((n == {count_width{1'b0}}) || (n > BPW_C)) begin
            return BPW_C;
        end else begin
            return n;
        end
    endfunction

    // Input readiness: idle, or the last held byte leaves this very cycle.
    always_comb begin
        w_ready = 1'b0;
        if (reset) begin
            w_ready = 1'b0;
        end else if (r_state == ST_EMPTY) begin
            w_ready = 1'b1;
        end else begin
            w_ready = (r_rem == ONE_C) && byte_out_ready;
        end
    end

    assign w_accept = word_in_valid && w_ready;
    assign w_xfer   = (r_state == ST_ACTIVE) && byte_out_ready;

    // Next-state: a new word overrides the shift because it only loads once the old word drains.
    always_comb begin
        w_state_nxt      = r_state;
        w_sreg_nxt       = r_sreg;
        w_rem_nxt        = r_rem;
        w_pkt_last_nxt   = r_pkt_last;
        w_bytes_sent_nxt = r_bytes_sent;
        if (w_xfer) begin
            w_bytes_sent_nxt = r_bytes_sent + 16'd1;
        end else begin
            w_bytes_sent_nxt = r_bytes_sent;
        end
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_sreg_nxt     = word_in_data;
                    w_rem_nxt      = clamp_nbytes(word_in_nbytes);
                    w_pkt_last_nxt = word_in_last;
                    w_state_nxt    = ST_ACTIVE;
                end else begin
                    w_state_nxt    = ST_EMPTY;
                end
            end
            ST_ACTIVE: begin
                if (w_accept) begin
                    w_sreg_nxt     = word_in_data;
                    w_rem_nxt      = clamp_nbytes(word_in_nbytes);
                    w_pkt_last_nxt = word_in_last;
                    w_state_nxt    = ST_ACTIVE;
                end else if (w_xfer) begin
                    w_sreg_nxt = {r_sreg[W-9:0], 8'h00};
                    w_rem_nxt  = r_rem - ONE_C;
                    if (r_rem == ONE_C) begin
                        w_state_nxt = ST_EMPTY;
                    end else begin
                        w_state_nxt = ST_ACTIVE;
                    end
                end else begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // State register with synchronous reset; held bytes are discarded on reset.
    always_ff @(posedge clk_core) begin
        if (reset) begin
            r_state      <= ST_EMPTY;
            r_sreg       <= {W{1'b0}};
            r_rem        <= {count_width{1'b0}};
            r_pkt_last   <= 1'b0;
            r_bytes_sent <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_sreg       <= w_sreg_nxt;
            r_rem        <= w_rem_nxt;
            r_pkt_last   <= w_pkt_last_nxt;
            r_bytes_sent <= w_bytes_sent_nxt;
        end
    end

    assign word_in_ready  = w_ready;
    assign byte_out_valid = (r_state == ST_ACTIVE);
    assign byte_out_data  = r_sreg[W-1 -: 8];
    assign byte_out_last  = r_pkt_last && (r_rem == ONE_C);
    assign bytes_sent     = r_bytes_sent;

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Bench for fifo_word_unpacker: directed scenarios plus random traffic checked
// against a byte-queue reference model; a second 4-byte instance covers nbytes=0.
module tb_fifo_word_unpacker;

    logic        clk_core = 1'b0;
    logic        reset;

    logic        in_ready;
    logic        in_valid;
    logic [15:0] in_data;
    logic [3:0]  in_nbytes;
    logic        in_last;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic [15:0] sent;

    logic        w4_in_ready;
    logic        w4_in_valid;
    logic [31:0] w4_in_data;
    logic [3:0]  w4_in_nbytes;
    logic        w4_in_last;
    logic        w4_out_ready;
    logic        w4_out_valid;
    logic [7:0]  w4_out_data;
    logic        w4_out_last;
    logic [15:0] w4_sent;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [8:0]  exp_q[$];
    logic [15:0] exp_sent;

    always #5 clk_core = ~clk_core;

    fifo_word_unpacker #(.bytes_per_word(2), .count_width(4)) u_dut2 (
        .clk_core       (clk_core),
        .reset          (reset),
        .word_in_ready  (in_ready),
        .word_in_valid  (in_valid),
        .word_in_data   (in_data),
        .word_in_nbytes (in_nbytes),
        .word_in_last   (in_last),
        .byte_out_ready (out_ready),
        .byte_out_valid (out_valid),
        .byte_out_data  (out_data),
        .byte_out_last  (out_last),
        .bytes_sent     (sent)
    );

    fifo_word_unpacker #(.bytes_per_word(4), .count_width(4)) u_dut4 (
        .clk_core       (clk_core),
        .reset          (reset),
        .word_in_ready  (w4_in_ready),
        .word_in_valid  (w4_in_valid),
        .word_in_data   (w4_in_data),
        .word_in_nbytes (w4_in_nbytes),
        .word_in_last   (w4_in_last),
        .byte_out_ready (w4_out_ready),
        .byte_out_valid (w4_out_valid),
        .byte_out_data  (w4_out_data),
        .byte_out_last  (w4_out_last),
        .bytes_sent     (w4_sent)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: an accepted word becomes its list of valid bytes, MSB first.
    task automatic push_word(input logic [15:0] d, input logic [3:0] n, input logic l);
        int k;
        k = ((n == 4'd0) || (n > 4'd2)) ? 2 : int'(n);
        for (int i = 0; i < k; i++) begin
            exp_q.push_back({l && (i == k - 1), d[(1 - i) * 8 +: 8]});
        end
    endtask

    // One clock of traffic on the 2-byte instance, entered and left just after a falling edge.
    task automatic cycle(input logic v, input logic [15:0] d, input logic [3:0] n,
                         input logic l, input logic r);
        logic exp_rdy;
        logic acc;
        logic xfer;
        in_valid  = v;
        in_data   = d;
        in_nbytes = n;
        in_last   = l;
        out_ready = r;
        #1;
        exp_rdy = (exp_q.size() == 0) || ((exp_q.size() == 1) && r);
        chk_eq("in_ready", in_ready, exp_rdy);
        chk_eq("out_valid", out_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            chk_eq("out_data", out_data, exp_q[0][7:0]);
            chk_eq("out_last", out_last, exp_q[0][8]);
        end
        chk_eq("bytes_sent", sent, exp_sent);
        acc  = v && exp_rdy;
        xfer = (exp_q.size() > 0) && r;
        @(posedge clk_core);
        if (xfer) begin
            void'(exp_q.pop_front());
            exp_sent++;
        end
        if (acc) push_word(d, n, l);
        @(negedge clk_core);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        w4_in_valid = 1'b0;
        @(posedge clk_core);
        @(posedge clk_core);
        @(negedge clk_core);
        chk_eq("rst_in_ready", in_ready, 32'd0);
        chk_eq("rst_valid", out_valid, 32'd0);
        chk_eq("rst_data", out_data, 32'd0);
        chk_eq("rst_last", out_last, 32'd0);
        chk_eq("rst_sent", sent, 32'd0);
        exp_q.delete();
        exp_sent = 16'd0;
        reset = 1'b0;
        #1;
        chk_eq("post_rst_ready", in_ready, 32'd1);
    endtask

    initial begin
        logic [31:0] ref4;
        in_data      = 16'h0000;
        in_nbytes    = 4'd0;
        in_last      = 1'b0;
        w4_in_data   = 32'h0;
        w4_in_nbytes = 4'd0;
        w4_in_last   = 1'b0;
        w4_out_ready = 1'b1;
        exp_sent     = 16'd0;
        do_reset();

        // Four-byte instance: nbytes=0 means the full word.
        ref4         = 32'h11223344;
        w4_in_valid  = 1'b1;
        w4_in_data   = ref4;
        w4_in_nbytes = 4'd0;
        w4_in_last   = 1'b1;
        #1;
        chk_eq("w4_ready", w4_in_ready, 32'd1);
        @(posedge clk_core);
        @(negedge clk_core);
        w4_in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_eq("w4_valid", w4_out_valid, 32'd1);
            chk_eq("w4_data", w4_out_data, ref4[(3 - k) * 8 +: 8]);
            chk_eq("w4_last", w4_out_last, k == 3);
            @(negedge clk_core);
        end
        chk_eq("w4_done", w4_out_valid, 32'd0);
        chk_eq("w4_sent", w4_sent, 32'd4);

        // Single full word with packet end.
        cycle(1'b1, 16'hA1B2, 4'd2, 1'b1, 1'b1);
        cycle(1'b0, 16'h0000, 4'd0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 4'd0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 4'd0, 1'b0, 1'b1);
        chk_eq("a1b2_sent", sent, 32'd2);

        // Back-to-back words; second one loads as 02 leaves.
        cycle(1'b1, 16'h0102, 4'd2, 1'b0, 1'b1);
        cycle(1'b1, 16'h0304, 4'd2, 1'b1, 1'b1);
        cycle(1'b1, 16'h0304, 4'd2, 1'b1, 1'b1);
        cycle(1'b0, 16'h0000, 4'd0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 4'd0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 4'd0, 1'b0, 1'b1);

        // Partial word: D4 must never appear.
        cycle(1'b1, 16'hC3D4, 4'd1, 1'b1, 1'b1);
        cycle(1'b0, 16'h0000, 4'd0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 4'd0, 1'b0, 1'b1);

        // Backpressure holds 66 stable.
        cycle(1'b1, 16'h5566, 4'd2, 1'b1, 1'b1);
        cycle(1'b0, 16'h0000, 4'd0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 4'd0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 4'd0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 4'd0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 4'd0, 1'b0, 1'b1);

        // Reset mid-word discards 88, then normal operation resumes.
        cycle(1'b1, 16'h7788, 4'd2, 1'b1, 1'b1);
        cycle(1'b0, 16'h0000, 4'd0, 1'b0, 1'b1);
        do_reset();
        cycle(1'b1, 16'h99AA, 4'd2, 1'b1, 1'b1);
        cycle(1'b0, 16'h0000, 4'd0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 4'd0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 4'd0, 1'b0, 1'b1);
        chk_eq("99aa_sent", sent, 32'd2);

        // Random traffic with random backpressure and byte counts 0..5.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            cycle($urandom_range(0, 9) < 7, 16'($urandom), 4'($urandom_range(0, 5)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
